// File: rtl/bp_pkg.sv
// Shared types for the fetch-stage next-PC generator and its prediction pipeline.
package bp_pkg;

    // Source chosen for the next fetch address, lowest to highest priority.
    typedef enum logic [2:0] {
        SEL_PC4   = 3'd0,
        SEL_PRED  = 3'd1,
        SEL_JALD  = 3'd2,
        SEL_JALRE = 3'd3,
        SEL_RECOV = 3'd4
    } npc_sel_t;

    // Prediction carried alongside an instruction through ID and EX.
    typedef struct packed {
        logic        valid;
        logic        pred;
        logic [31:0] npc_pred;
    } pred_info_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam pred_info_t  PRED_INFO_NULL   = '0;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_npc_unit_pred_stage.sv
// One pipeline register for prediction info with stall hold and flush-to-bubble.
module pred_stage_reg
    import bp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       stall_i,
    input  logic       flush_i,
    input  pred_info_t d_i,
    output pred_info_t q_o
);

    pred_info_t state_q;
    pred_info_t state_d;

    // Flush wins over stall so a squashed instruction never lingers as valid.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = PRED_INFO_NULL;
        end else if (!stall_i) begin
            state_d = d_i;
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PRED_INFO_NULL;
        end else begin
            state_q <= state_d;
        end
    end

    assign q_o = state_q;

endmodule

// File: rtl/fetch_npc_unit.sv
// Fetch-stage next-PC generator: owns PCF, tracks predictions through ID/EX,
// detects EX mispredictions and keeps branch/mispredict statistics.
module fetch_npc_unit
    import bp_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PredF,
    input  logic [31:0]      NPC_PredF,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             StallE,
    input  logic             FlushD,
    input  logic             FlushE,
    input  logic             JalD,
    input  logic [31:0]      JalNPC,
    input  logic             JalrE,
    input  logic [31:0]      JalrNPC,
    input  logic             BrTypeE,
    input  logic             BranchE,
    input  logic [31:0]      BrNPC,
    input  logic [31:0]      PCE,
    output logic [31:0]      PCF,
    output logic             PredE,
    output logic [31:0]      NPC_PredE,
    output logic             MispredE,
    output logic [CNT_W-1:0] BrCnt,
    output logic [CNT_W-1:0] MissCnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pred_info_t       id_d;
    pred_info_t       id_q;
    pred_info_t       ex_q;

    logic [31:0]      pcf_q;
    logic [31:0]      pcf_d;
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] br_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q;
    logic [CNT_W-1:0] miss_cnt_d;

    logic             mis_not_taken;
    logic             mis_taken;
    logic             mis_target;
    logic             mis_stale;
    logic             br_miss;
    logic             mispred;
    logic [31:0]      recov_pc;
    npc_sel_t         npc_sel;
    logic [31:0]      npc;
    logic             pcf_load;
    logic             cnt_en;

    assign id_d = '{valid: 1'b1, pred: PredF, npc_pred: NPC_PredF};

    pred_stage_reg u_stage_id (
        .clk     (clk),
        .rst     (rst),
        .stall_i (StallD),
        .flush_i (FlushD),
        .d_i     (id_d),
        .q_o     (id_q)
    );

    pred_stage_reg u_stage_ex (
        .clk     (clk),
        .rst     (rst),
        .stall_i (StallE),
        .flush_i (FlushE),
        .d_i     (id_q),
        .q_o     (ex_q)
    );

    // Classify the EX-stage outcome against the prediction it carried.
    always_comb begin
        mis_not_taken = ex_q.valid & BrTypeE & ex_q.pred & ~BranchE;
        mis_taken     = ex_q.valid & BrTypeE & ~ex_q.pred & BranchE;
        mis_target    = ex_q.valid & BrTypeE & ex_q.pred & BranchE
                        & (ex_q.npc_pred != BrNPC);
        // A predicted-taken non-branch means the BHT entry is stale (aliased).
        mis_stale     = ex_q.valid & ~BrTypeE & ex_q.pred;
        br_miss       = mis_not_taken | mis_taken | mis_target;
        mispred       = br_miss | mis_stale;
        recov_pc      = (mis_not_taken | mis_stale) ? pc_plus4(PCE) : BrNPC;
    end

    // Next-PC source priority: recovery, jalr in EX, jal in ID, prediction, sequential.
    always_comb begin
        npc_sel = SEL_PC4;
        if (mispred) begin
            npc_sel = SEL_RECOV;
        end else if (JalrE) begin
            npc_sel = SEL_JALRE;
        end else if (JalD) begin
            npc_sel = SEL_JALD;
        end else if (PredF) begin
            npc_sel = SEL_PRED;
        end
    end

    // Next-PC mux.
    always_comb begin
        npc = pc_plus4(pcf_q);
        case (npc_sel)
            SEL_RECOV: npc = recov_pc;
            SEL_JALRE: npc = JalrNPC;
            SEL_JALD:  npc = JalNPC;
            SEL_PRED:  npc = NPC_PredF;
            default:   npc = pc_plus4(pcf_q);
        endcase
    end

    // Redirects from EX override a fetch stall; everything else respects it.
    always_comb begin
        pcf_load = ~StallF | mispred | JalrE;
        pcf_d    = pcf_load ? npc : pcf_q;
    end

    // Statistics count only real conditional branches leaving EX.
    always_comb begin
        cnt_en     = ex_q.valid & BrTypeE & ~StallE;
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (cnt_en) begin
            br_cnt_d = br_cnt_q + CNT_ONE;
            if (br_miss) begin
                miss_cnt_d = miss_cnt_q + CNT_ONE;
            end
        end
    end

    // Fetch PC and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcf_q      <= RESET_PC;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            pcf_q      <= pcf_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign PCF       = pcf_q;
    assign PredE     = ex_q.pred;
    assign NPC_PredE = ex_q.npc_pred;
    assign MispredE  = mispred;
    assign BrCnt     = br_cnt_q;
    assign MissCnt   = miss_cnt_q;

endmodule

// File: doc/fetch_npc_unit.md
# fetch_npc_unit

Fetch-stage next-PC generator and prediction tracker sitting directly upstream of the BHT. Owns the PCF register, chooses the next fetch address from the BHT's PredF/NPC_PredF, ID/EX jump targets and EX branch resolution. Carries the prediction alongside the instruction through ID and EX, so the BHT update port receives PredE/NPC_PredE. Detects mispredictions in EX, issues the redirect and flush request, and keeps branch and mispredict statistics.

## Interface
- RESET_PC, 32'h0000_0000, PCF value after reset
- CNT_W, 32, width of statistics counters

- clk  in  1  single clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- PredF  in  1  BHT predict-taken for PCF
- NPC_PredF  in  32  BHT predicted target for PCF
- StallF / StallD / StallE  in  1 each  hold the respective stage register
- FlushD / FlushE  in  1 each  bubble the respective stage (from hazard unit)
- JalD  in  1  jal decoded in ID; JalNPC  in  32  its target
- JalrE  in  1  jalr in EX; JalrNPC  in  32  its target
- BrTypeE  in  1  instruction in EX is a conditional branch
- BranchE  in  1  EX branch actually taken
- BrNPC  in  32  EX actual branch target
- PCE  in  32  PC of instruction in EX
- PCF  out  32  current fetch PC (registered)
- PredE  out  1  prediction carried to EX (to BHT)
- NPC_PredE  out  32  predicted target carried to EX (to BHT)
- MispredE  out  1  EX redirect request; hazard unit must flush D and E
- BrCnt  out  CNT_W  valid conditional branches resolved
- MissCnt  out  CNT_W  mispredicted conditional branches

## Operation
- Stage registers ID and EX each hold {Valid, Pred, NPC_Pred}. ID loads {1, PredF, NPC_PredF}; EX loads ID contents.
- Stall holds the register. Flush loads {0,0,0}. Flush beats stall.
- Mispredict (combinational from EX regs, gated by ValidE):
  - BrTypeE & PredE & !BranchE -> redirect PCE+4
  - BrTypeE & !PredE & BranchE -> redirect BrNPC
  - BrTypeE & PredE & BranchE & NPC_PredE != BrNPC -> redirect BrNPC
  - !BrTypeE & PredE -> redirect PCE+4 (stale entry)
  - MispredE = any of the above.
- Next-PC priority, highest first: MispredE target, JalrE -> JalrNPC, JalD -> JalNPC, PredF -> NPC_PredF, else PCF+4.
- PCF update: loads next-PC when !StallF. MispredE and JalrE load even if StallF is high, because a redirect overrides the stall.
- PC arithmetic: 32-bit, modulo 2^32; 32'hFFFF_FFFC+4 = 0.
- Counters, on ValidE & BrTypeE & !StallE:
  - BrCnt+1.
  - MissCnt+1 when the branch is mispredicted; the !BrTypeE stale case is not counted.
  - Both counters wrap at 2^CNT_W.

## Timing
- Reset (rst high at posedge): PCF=RESET_PC; all Valid/Pred=0 and NPC_Pred=0; BrCnt=MissCnt=0. Consequently PredE=0, NPC_PredE=0, MispredE=0.
- Reset mid-stream: all pending predictions are discarded and no counter update occurs that cycle.
- PredF/NPC_PredF are sampled in the cycle that PCF is presented. Prediction is visible at EX two cycles later, absent stalls.
- Predicted-taken redirect: zero bubbles. PCF = NPC_PredF on the next edge.
- Mispredict penalty:
  - MispredE is asserted combinationally in the cycle the branch is in EX.
  - PCF takes the corrected target at the next edge.
  - The two younger instructions are flushed by the hazard unit.
- Simultaneous MispredE and JalD: MispredE wins, because the JalD instruction is on the wrong path.
- The BHT samples PredE/NPC_PredE on negedge. Values must be stable for the whole EX cycle, which is guaranteed because they are register outputs.

## Structure
- Shared package bp_pkg:
  - npc_sel_t enum {SEL_PC4, SEL_PRED, SEL_JALD, SEL_JALRE, SEL_RECOV}
  - typedef pred_info_t {logic valid; logic pred; logic [31:0] npc_pred;}
  - RESET_PC default constant
- Sub-module pred_stage_reg: one stall/flush pipeline register of pred_info_t, instantiated for ID and EX.

## Test plan
- Reset: rst high 2 cycles then low with no predictions -> PCF=0, then 4, 8, 12 on successive cycles; BrCnt=MissCnt=0.
- Correct taken prediction: PCF=0x20, PredF=1, NPC_PredF=0x80 -> next PCF=0x80. Two cycles later, with BrTypeE=1, BranchE=1, BrNPC=0x80: MispredE=0, BrCnt=1, MissCnt=0.
- Predicted taken, not taken: PredE=1, BranchE=0, PCE=0x20 -> MispredE=1, next PCF=0x24, MissCnt=1.
- Not predicted, taken: PredE=0, BranchE=1, BrNPC=0x100 -> MispredE=1, next PCF=0x100. Same cycle JalD=1, JalNPC=0x200 is ignored.
- Stall/flush: StallF=StallD=1 for 3 cycles -> PCF and PredD held. Then FlushE=1 -> EX bubble, no counter increment even with BrTypeE=1. Redirect during StallF still loads PCF.
- Wrap: PCF=0xFFFF_FFFC, PredF=0 -> PCF=0. With CNT_W=4, 16 branches -> BrCnt=0.
